// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, signed/unsigned
// operands, start/done handshake and divide-by-zero reporting.
module div_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quociente,
    output logic [N-1:0] resto,
    output logic         div_zero
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sq_q, sq_d;
    logic          sr_q, sr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  res_q, res_d;
    logic          dz_q, dz_d;

    logic          dvd_neg, dvs_neg;
    logic [N-1:0]  dvd_mag, dvs_mag;
    logic [2*N:0]  shift;
    logic [N:0]    trial;

    always_comb begin
        dvd_neg = signed_mode & dividendo[N-1];
        dvs_neg = signed_mode & divisor[N-1];
        dvd_mag = dvd_neg ? -dividendo : dividendo;
        dvs_mag = dvs_neg ? -divisor : divisor;
    end

    // {A,Q} shifted as one word; trial sign bit (bit N) selects restore.
    always_comb begin
        shift = {a_q, q_q} << 1;
        trial = shift[2*N:N] - {1'b0, m_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        res_d   = res_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quo_d  = '1;
                        res_d  = dividendo;
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        a_d     = '0;
                        q_d     = dvd_mag;
                        m_d     = dvs_mag;
                        sq_d    = signed_mode & (dividendo[N-1] ^ divisor[N-1]);
                        sr_d    = signed_mode & dividendo[N-1];
                        cnt_d   = CW'(N);
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                q_d = shift[N-1:0];
                if (!trial[N]) begin
                    a_d    = trial;
                    q_d[0] = 1'b1;
                end else begin
                    a_d    = shift[2*N:N];
                    q_d[0] = 1'b0;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                quo_d   = sq_q ? -q_q : q_q;
                res_d   = sr_q ? -a_q[N-1:0] : a_q[N-1:0];
                dz_d    = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quociente = quo_q;
    assign resto     = res_q;
    assign div_zero  = dz_q;

endmodule
